// File: rtl/rom_loader.sv
// Packs the byte-serial ROM stream into 16-bit words and writes them to memory.
// Ports: clk/resetn, rom_* byte input, mem_* write port, hdr_* header mirror, status outputs.
// Optional feature macro: ROM_LOADER_CHECKSUM_EN enables the byte-sum checksum.
module rom_loader #(
  parameter int              ADDR_W     = 22,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              FIFO_DEPTH = 8,
  parameter int              HDR_BYTES  = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rom_loading,
  input  logic [7:0]        rom_do,
  input  logic              rom_do_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              hdr_we,
  output logic [7:0]        hdr_addr,
  output logic [7:0]        hdr_data,
  output logic [23:0]       rom_size,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [15:0]       checksum
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH
  } state_t;

  state_t state, state_nxt;

  logic ld_q, ld_qq;
  logic rise, fall;
  logic restart_pending;
  logic load_start;
  logic byte_ok;
  logic drained;

  logic        odd;
  logic [7:0]  low_byte;
  logic [ADDR_W-1:0] word_index;

  logic [15:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   cnt, cnt_nxt;
  logic          full;
  logic          push, pop, wr_en, drop;
  logic [15:0]   push_data;

  assign rise = ld_q & ~ld_qq;
  assign fall = ~ld_q & ld_qq;

  assign full    = (cnt == (PW+1)'(FIFO_DEPTH));
  assign drained = (cnt == '0) && !mem_we;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (rise || restart_pending) state_nxt = S_LOAD;
      S_LOAD:  if (fall) state_nxt = S_FLUSH;
      S_FLUSH: if (drained) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_FLUSH) && drained;
    byte_ok    = (state == S_LOAD) && rom_do_valid;
    load_start = (state == S_IDLE) && (rise || restart_pending);
  end

  // Word assembly; a falling edge flushes a pending low byte as a padded word
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (byte_ok && odd) begin
      push      = 1'b1;
      push_data = {rom_do, low_byte};
    end else if ((state == S_LOAD) && fall && byte_ok) begin
      push      = 1'b1;
      push_data = {8'h00, rom_do};
    end else if ((state == S_LOAD) && fall && odd) begin
      push      = 1'b1;
      push_data = {8'h00, low_byte};
    end
  end

  assign pop     = mem_we & mem_ack;
  assign wr_en   = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign cnt_nxt = cnt + {{PW{1'b0}}, wr_en} - {{PW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (wr_en) fifo[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ld_q            <= 1'b0;
      ld_qq           <= 1'b0;
      restart_pending <= 1'b0;
      odd             <= 1'b0;
      low_byte        <= '0;
      word_index      <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      cnt             <= '0;
      mem_we          <= 1'b0;
      rom_size        <= '0;
      overflow        <= 1'b0;
      hdr_we          <= 1'b0;
      hdr_addr        <= '0;
      hdr_data        <= '0;
    end else begin
      ld_q  <= rom_loading;
      ld_qq <= ld_q;

      if (load_start)
        restart_pending <= 1'b0;
      else if (rise && (state == S_FLUSH))
        restart_pending <= 1'b1;

      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt_nxt;
      // Head word is presented as soon as the FIFO holds one
      mem_we <= (cnt_nxt != '0);

      if (load_start)
        word_index <= '0;
      else if (pop)
        word_index <= word_index + 1'b1;

      if (load_start)
        odd <= 1'b0;
      else if ((state == S_LOAD) && fall)
        odd <= 1'b0;
      else if (byte_ok)
        odd <= ~odd;

      if (byte_ok && !odd) low_byte <= rom_do;

      if (load_start)
        rom_size <= '0;
      else if (byte_ok && (rom_size != 24'hFFFFFF))
        rom_size <= rom_size + 24'd1;

      if (load_start)
        overflow <= 1'b0;
      else if (drop)
        overflow <= 1'b1;

      hdr_we <= byte_ok && (rom_size < 24'(HDR_BYTES));
      if (byte_ok) begin
        hdr_addr <= rom_size[7:0];
        hdr_data <= rom_do;
      end
    end
  end

  assign mem_din  = mem_we ? fifo[rd_ptr] : '0;
  assign mem_addr = mem_we ? (BASE_ADDR + word_index) : '0;

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] sum;

  always_ff @(posedge clk) begin
    if (!resetn)
      sum <= '0;
    else if (load_start)
      sum <= '0;
    else if (byte_ok)
      sum <= sum + {8'h00, rom_do};
  end

  assign checksum = sum;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: directed byte streams, queued expected writes.
// A negedge monitor pops and compares memory writes and header strobes.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rom_loading = 1'b0;
  logic [7:0]  rom_do = '0;
  logic        rom_do_valid = 1'b0;
  logic [21:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic        mem_ack = 1'b0;
  logic        hdr_we;
  logic [7:0]  hdr_addr;
  logic [7:0]  hdr_data;
  logic [23:0] rom_size;
  logic        busy, done, overflow;
  logic [15:0] checksum;

  logic        w_loading = 1'b0;
  logic [7:0]  w_do = '0;
  logic        w_valid = 1'b0;
  logic [3:0]  w_addr;
  logic [15:0] w_din;
  logic        w_we, w_ack;
  logic        w_hdr_we;
  logic [7:0]  w_hdr_addr, w_hdr_data;
  logic [23:0] w_size;
  logic        w_busy, w_done, w_ovf;
  logic [15:0] w_sum;

  always #5 clk = ~clk;

  rom_loader dut (
    .clk(clk), .resetn(resetn),
    .rom_loading(rom_loading), .rom_do(rom_do), .rom_do_valid(rom_do_valid),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_ack(mem_ack),
    .hdr_we(hdr_we), .hdr_addr(hdr_addr), .hdr_data(hdr_data),
    .rom_size(rom_size), .busy(busy), .done(done),
    .overflow(overflow), .checksum(checksum)
  );

  rom_loader #(.ADDR_W(4), .BASE_ADDR(4'd14)) u_wrap (
    .clk(clk), .resetn(resetn),
    .rom_loading(w_loading), .rom_do(w_do), .rom_do_valid(w_valid),
    .mem_addr(w_addr), .mem_din(w_din), .mem_we(w_we), .mem_ack(w_ack),
    .hdr_we(w_hdr_we), .hdr_addr(w_hdr_addr), .hdr_data(w_hdr_data),
    .rom_size(w_size), .busy(w_busy), .done(w_done),
    .overflow(w_ovf), .checksum(w_sum)
  );

  assign w_ack = w_we;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int hdr_cnt = 0;
  logic stall = 1'b1;

  logic [37:0] wq[$];
  logic [15:0] hq[$];
  logic [19:0] wwq[$];

  int          m_cnt, m_widx, m_words, m_limit, m_sum;
  logic        m_odd;
  logic [7:0]  m_low;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write acknowledge one cycle after mem_we is seen, unless stalled
  always @(posedge clk) begin
    #1;
    mem_ack = !stall && mem_we && !mem_ack;
  end

  logic [37:0] me;
  logic [15:0] mh;
  logic [19:0] mw;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (hdr_we) begin
      hdr_cnt++;
      if (hq.size() == 0) chk("hdr_unexpected", 1, 0);
      else begin
        mh = hq.pop_front();
        chk("hdr_addr", {24'h0, hdr_addr}, {24'h0, mh[15:8]});
        chk("hdr_data", {24'h0, hdr_data}, {24'h0, mh[7:0]});
      end
    end
    if (mem_we && mem_ack) begin
      if (wq.size() == 0) chk("write_unexpected", 1, 0);
      else begin
        me = wq.pop_front();
        chk("mem_addr", {10'h0, mem_addr}, {10'h0, me[37:16]});
        chk("mem_din", {16'h0, mem_din}, {16'h0, me[15:0]});
      end
    end
    if (w_we) begin
      if (wwq.size() == 0) chk("wrap_unexpected", 1, 0);
      else begin
        mw = wwq.pop_front();
        chk("wrap_addr", {28'h0, w_addr}, {28'h0, mw[19:16]});
        chk("wrap_din", {16'h0, w_din}, {16'h0, mw[15:0]});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic begin_load(input int limit);
    m_cnt = 0; m_widx = 0; m_words = 0; m_sum = 0;
    m_odd = 1'b0; m_low = '0; m_limit = limit;
    rom_loading = 1'b1;
    cyc(3);
  endtask

  task automatic push_word(input logic [15:0] w);
    if (m_words < m_limit) begin
      wq.push_back({m_widx[21:0], w});
      m_widx++;
    end
    m_words++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (m_cnt < 64) hq.push_back({m_cnt[7:0], b});
    if (m_odd) push_word({b, m_low});
    else m_low = b;
    m_odd = ~m_odd;
    m_sum = (m_sum + b) & 16'hFFFF;
    m_cnt++;
    rom_do = b;
    rom_do_valid = 1'b1;
    cyc(1);
    rom_do_valid = 1'b0;
    cyc(1);
  endtask

  task automatic end_load;
    int t0;
    t0 = done_cnt;
    if (m_odd) push_word({8'h00, m_low});
    m_odd = 1'b0;
    rom_loading = 1'b0;
    for (int i = 0; i < 600 && done_cnt == t0; i++) @(posedge clk);
    cyc(3);
    chk("done_pulses", done_cnt - t0, 1);
    chk("busy_after", {31'h0, busy}, 0);
  endtask

  logic [21:0] a0;
  logic [15:0] d0;

  initial begin
    // Reset state
    cyc(3);
    chk("rst_mem_we", {31'h0, mem_we}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_ovf", {31'h0, overflow}, 0);
    chk("rst_size", {8'h0, rom_size}, 0);
    chk("rst_hdr_we", {31'h0, hdr_we}, 0);
    chk("rst_cksum", {16'h0, checksum}, 0);
    chk("rst_din", {16'h0, mem_din}, 0);
    resetn = 1'b1;
    stall = 1'b0;
    cyc(2);

    // Four bytes, two full words
    begin_load(1000);
    send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h44);
    end_load();
    chk("size4", {8'h0, rom_size}, 4);
`ifdef ROM_LOADER_CHECKSUM_EN
    chk("cksum4", {16'h0, checksum}, 32'h00AA);
`else
    chk("cksum4", {16'h0, checksum}, 0);
`endif

    // Three bytes, padded final word
    begin_load(1000);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    end_load();
    chk("size3", {8'h0, rom_size}, 3);
`ifdef ROM_LOADER_CHECKSUM_EN
    chk("cksum3", {16'h0, checksum}, 32'h0231);
`else
    chk("cksum3", {16'h0, checksum}, 0);
`endif

    // 100 bytes: only the first 64 mirrored to the header port
    hdr_cnt = 0;
    begin_load(1000);
    for (int i = 0; i < 100; i++) send_byte(8'((i * 7 + 3) & 8'hFF));
    end_load();
    chk("hdr_count", hdr_cnt, 64);
    chk("size100", {8'h0, rom_size}, 100);
    chk("ovf100", {31'h0, overflow}, 0);

    // Stalled memory: FIFO fills, later words dropped
    stall = 1'b1;
    begin_load(8);
    for (int i = 0; i < 4; i++) send_byte(8'(i + 1));
    a0 = mem_addr;
    d0 = mem_din;
    chk("stall_we", {31'h0, mem_we}, 1);
    chk("stall_d0", {16'h0, d0}, 32'h0201);
    for (int i = 4; i < 40; i++) send_byte(8'(i + 1));
    cyc(110);
    chk("stall_addr", {10'h0, mem_addr}, {10'h0, a0});
    chk("stall_din", {16'h0, mem_din}, {16'h0, d0});
    chk("stall_ovf", {31'h0, overflow}, 1);
    stall = 1'b0;
    end_load();
    chk("ovf_sticky", {31'h0, overflow}, 1);
    chk("size40", {8'h0, rom_size}, 40);

    // Reset in the middle of a stalled load
    stall = 1'b1;
    begin_load(1000);
    for (int i = 0; i < 4; i++) send_byte(8'(8'hE0 + i));
    chk("pre_rst_we", {31'h0, mem_we}, 1);
    resetn = 1'b0;
    rom_loading = 1'b0;
    cyc(1);
    chk("rst_mid_we", {31'h0, mem_we}, 0);
    chk("rst_mid_busy", {31'h0, busy}, 0);
    chk("rst_mid_size", {8'h0, rom_size}, 0);
    wq.delete();
    cyc(1);
    resetn = 1'b1;
    stall = 1'b0;
    cyc(2);
    begin_load(1000);
    send_byte(8'h5A); send_byte(8'hA5);
    end_load();
    chk("size_after_rst", {8'h0, rom_size}, 2);

    // Address wrap on the narrow instance
    wwq.push_back({4'd14, 16'h0201});
    wwq.push_back({4'd15, 16'h0403});
    wwq.push_back({4'd0, 16'h0605});
    w_loading = 1'b1;
    cyc(3);
    for (int i = 0; i < 6; i++) begin
      w_do = 8'(i + 1);
      w_valid = 1'b1;
      cyc(1);
      w_valid = 1'b0;
      cyc(1);
    end
    w_loading = 1'b0;
    for (int i = 0; i < 100 && w_busy; i++) @(posedge clk);
    cyc(3);
    chk("wrap_busy", {31'h0, w_busy}, 0);
    chk("wrap_left", wwq.size(), 0);
    chk("wrap_size", {8'h0, w_size}, 6);

    chk("writes_left", wq.size(), 0);
    chk("hdr_left", hq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
